mux32x32_sel: RTL and testbench

- Word-select multiplexer: picks one of 32 packed 32-bit words from a flat 1024-bit bus, using a 5-bit select.
- Provides a zero-latency combinational output for datapath use.
- Also provides a registered copy of that output for timing-critical consumers.
- Generic building block for register-file read ports and bus steering.

---
 rtl/mux32x32_sel.sv | 64 ++++++
 tb/tb_mux32x32_sel.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux32x32_sel.sv
// Word-select multiplexer: picks one WIDTH-bit word out of N packed words.
// Provides a combinational output y and an optional registered copy y_q.
module mux32x32_sel #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SEL_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N*WIDTH-1:0] a,
  input  logic [SEL_W-1:0]   s,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q
);

  localparam int LEAVES = 1 << SEL_W;

  // Heap-ordered tree: node i has children 2i and 2i+1, root at index 1.
  // Leaf k sits at index LEAVES+k, so the MSB of s steers the root.
  logic [WIDTH-1:0] tree [1:2*LEAVES-1];

  genvar gi, gd;

  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < N) begin : g_word
        assign tree[LEAVES+gi] = a[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        // Padded leaves read as zero so out-of-range selects give y = 0.
        assign tree[LEAVES+gi] = '0;
      end
    end

    for (gd = 0; gd < SEL_W; gd++) begin : g_level
      for (gi = 0; gi < (1 << gd); gi++) begin : g_node
        assign tree[(1 << gd) + gi] = s[SEL_W-1-gd] ? tree[2*((1 << gd) + gi) + 1]
                                                   : tree[2*((1 << gd) + gi)];
      end
    end
  endgenerate

  assign y = tree[1];

  // Output register: reset wins over enable.
  logic [WIDTH-1:0] yr_d;
  logic [WIDTH-1:0] yr_q;

  always_comb begin
    yr_d = yr_q;
    if (rst) begin
      yr_d = '0;
    end else if (ena) begin
      yr_d = y;
    end
  end

  always_ff @(posedge clk) begin
    yr_q <= yr_d;
  end

  assign y_q = yr_q;

endmodule

// File: tb/tb_mux32x32_sel.sv
// Self-checking bench for mux32x32_sel: directed steps plus randomized
// comparison against a word-array reference model.
module tb_mux32x32_sel;

  localparam int WIDTH = 32;
  localparam int N     = 32;
  localparam int SEL_W = 5;

  logic               clk;
  logic               rst;
  logic               ena;
  logic [N*WIDTH-1:0] a;
  logic [SEL_W-1:0]   s;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   y_q;

  logic [WIDTH-1:0] words [N];
  int errors;
  int checks;

  mux32x32_sel #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .a   (a),
    .s   (s),
    .y   (y),
    .y_q (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pack the model's word array onto the bus and let it settle.
  task automatic apply();
    for (int k = 0; k < N; k++) a[k*WIDTH +: WIDTH] = words[k];
    #1;
  endtask

  function automatic logic [WIDTH-1:0] model_y(input int sel);
    return (sel < N) ? words[sel] : '0;
  endfunction

  initial begin
    logic [WIDTH-1:0] yq_exp;
    logic [WIDTH-1:0] y_before;
    logic             r_bit;
    logic             e_bit;
    int               sel;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    ena = 1'b0;
    s   = '0;
    for (int k = 0; k < N; k++) words[k] = '0;
    apply();

    // Reset for two edges
    @(posedge clk); @(posedge clk); #1;
    check("reset_yq", y_q, 32'h0);

    // Walking select
    for (int k = 0; k < N; k++) words[k] = 32'h01010101 * k + 32'hA5000000;
    apply();
    for (int k = 0; k < N; k++) begin
      s = SEL_W'(k);
      #1;
      check($sformatf("walk_s%0d", k), y, 32'h01010101 * k + 32'hA5000000);
      $display("walk s=%0d y=%h", k, y);
    end
    s = 5'd31; #1;
    check("walk_s31_const", y, 32'hC41F1F1F);

    // Boundary words
    for (int k = 0; k < N; k++) words[k] = '0;
    words[0]  = 32'hDEADBEEF;
    words[31] = 32'hCAFEF00D;
    apply();
    s = 5'd0;  #1; check("bound_s0", y, 32'hDEADBEEF);
    s = 5'd31; #1; check("bound_s31", y, 32'hCAFEF00D);
    s = 5'd1;  #1; check("bound_s1", y, 32'h00000000);

    // Isolation: only non-selected words change
    s = 5'd7;
    words[7] = 32'h7777_1234;
    apply();
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < N; k++) if (k != 7) words[k] = $urandom;
      apply();
      check("isolation", y, 32'h7777_1234);
    end

    // Random compare
    for (int it = 0; it < 1024; it++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      s = SEL_W'($urandom_range(0, 31));
      apply();
      check("random_y", y, model_y(int'(s)));
      if ((it % 128) == 0) $display("random it=%0d s=%0d y=%h", it, s, y);
    end

    // Register path: load, then hold
    rst = 1'b1; ena = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reg_reset", y_q, 32'h0);
    rst = 1'b0; ena = 1'b1;
    words[3] = 32'h12345678;
    s = 5'd3;
    apply();
    @(posedge clk); #1;
    check("reg_load", y_q, 32'h12345678);
    ena = 1'b0;
    s = 5'd5;
    #1;
    check("reg_y_follows", y, words[5]);
    @(posedge clk); #1;
    check("reg_hold", y_q, 32'h12345678);

    // Reset priority over enable
    for (int k = 0; k < N; k++) words[k] = 32'hFFFFFFFF;
    apply();
    rst = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    check("rst_priority", y_q, 32'h0);
    check("rst_no_effect_y", y, 32'hFFFFFFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reload_after_rst", y_q, 32'hFFFFFFFF);

    // Randomized register traffic against a cycle model
    yq_exp = 32'hFFFFFFFF;
    for (int it = 0; it < 64; it++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      sel   = $urandom_range(0, 31);
      s     = SEL_W'(sel);
      r_bit = ($urandom_range(0, 7) == 0);
      e_bit = $urandom_range(0, 1) == 1;
      rst   = r_bit;
      ena   = e_bit;
      apply();
      y_before = model_y(sel);
      if (r_bit)      yq_exp = '0;
      else if (e_bit) yq_exp = y_before;
      @(posedge clk); #1;
      check("rand_reg", y_q, yq_exp);
    end
    rst = 1'b0; ena = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
